// File: rtl/change_payout.sv
// Change-return engine: pays a requested amount greedily as 25/10/5 coins over a
// valid/ack hopper handshake, tracking per-denomination inventory and any unpaid remainder.
module change_payout #(
   parameter int unsigned AMT_W  = 8,
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned INIT_Q = 20,
   parameter int unsigned INIT_D = 20,
   parameter int unsigned INIT_N = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   output logic             coin_valid,
   output logic [1:0]       coin_type,
   input  logic             coin_ack,
   input  logic             refill,
   output logic             done,
   output logic [AMT_W-1:0] shortfall,
   output logic [CNT_W-1:0] cnt_q,
   output logic [CNT_W-1:0] cnt_d,
   output logic [CNT_W-1:0] cnt_n
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_DISPENSE,
      S_FINISH
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_N    = 2'b01;
   localparam logic [1:0] COIN_D    = 2'b10;
   localparam logic [1:0] COIN_Q    = 2'b11;

   localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(25);
   localparam logic [AMT_W-1:0] VAL_D = AMT_W'(10);
   localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5);

   state_t           r_state;
   state_t           w_next;
   logic [AMT_W-1:0] r_rem;
   logic [1:0]       r_coin;
   logic [CNT_W-1:0] r_cnt_q;
   logic [CNT_W-1:0] r_cnt_d;
   logic [CNT_W-1:0] r_cnt_n;

   logic             w_accept;
   logic             w_ack;
   logic             w_refill;
   logic [1:0]       w_pick;
   logic [AMT_W-1:0] w_coin_val;

   assign w_accept = req_valid & (r_state == S_IDLE);
   assign w_ack    = coin_ack  & (r_state == S_DISPENSE);
   assign w_refill = refill    & (r_state == S_IDLE);

   // Largest affordable coin still in stock; an empty denomination is never picked.
   always_comb begin
      w_pick = COIN_NONE;
      if ((r_rem >= VAL_Q) && (r_cnt_q != '0)) begin
         w_pick = COIN_Q;
      end else if ((r_rem >= VAL_D) && (r_cnt_d != '0)) begin
         w_pick = COIN_D;
      end else if ((r_rem >= VAL_N) && (r_cnt_n != '0)) begin
         w_pick = COIN_N;
      end
   end

   always_comb begin
      w_coin_val = '0;
      case (r_coin)
         COIN_Q:  w_coin_val = VAL_Q;
         COIN_D:  w_coin_val = VAL_D;
         COIN_N:  w_coin_val = VAL_N;
         default: w_coin_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (w_accept) w_next = S_SELECT;
         S_SELECT:   w_next = (w_pick != COIN_NONE) ? S_DISPENSE : S_FINISH;
         S_DISPENSE: if (w_ack) w_next = S_SELECT;
         S_FINISH:   w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem  <= '0;
         r_coin <= COIN_NONE;
      end else begin
         if (w_accept) begin
            r_rem <= req_amount;
         end else if (w_ack) begin
            r_rem <= r_rem - w_coin_val;
         end
         if ((r_state == S_SELECT) && (w_pick != COIN_NONE)) begin
            r_coin <= w_pick;
         end
      end
   end

   // Refill is only possible in IDLE and an ack only in DISPENSE, so the two never collide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt_q <= CNT_W'(INIT_Q);
         r_cnt_d <= CNT_W'(INIT_D);
         r_cnt_n <= CNT_W'(INIT_N);
      end else if (w_refill) begin
         r_cnt_q <= CNT_W'(INIT_Q);
         r_cnt_d <= CNT_W'(INIT_D);
         r_cnt_n <= CNT_W'(INIT_N);
      end else if (w_ack) begin
         case (r_coin)
            COIN_Q:  r_cnt_q <= r_cnt_q - CNT_W'(1);
            COIN_D:  r_cnt_d <= r_cnt_d - CNT_W'(1);
            COIN_N:  r_cnt_n <= r_cnt_n - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Handshake outputs decode from state so a reset drops them without waiting for a clock.
   assign req_ready  = (r_state == S_IDLE);
   assign coin_valid = (r_state == S_DISPENSE);
   assign coin_type  = (r_state == S_DISPENSE) ? r_coin : COIN_NONE;
   assign done       = (r_state == S_FINISH);
   assign shortfall  = (r_state == S_FINISH) ? r_rem : '0;
   assign cnt_q      = r_cnt_q;
   assign cnt_d      = r_cnt_d;
   assign cnt_n      = r_cnt_n;

endmodule

// File: tb/tb_change_payout.sv
// Randomised bench for change_payout: each payout is compared against a greedy
// coin model holding its own inventory.
module tb_change_payout;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic [7:0] req_amount;
   logic       req_ready;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       coin_ack;
   logic       refill;
   logic       done;
   logic [7:0] shortfall;
   logic [5:0] cnt_q;
   logic [5:0] cnt_d;
   logic [5:0] cnt_n;

   change_payout #(
      .AMT_W (8),
      .CNT_W (6),
      .INIT_Q(20),
      .INIT_D(20),
      .INIT_N(20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_amount(req_amount),
      .req_ready (req_ready),
      .coin_valid(coin_valid),
      .coin_type (coin_type),
      .coin_ack  (coin_ack),
      .refill    (refill),
      .done      (done),
      .shortfall (shortfall),
      .cnt_q     (cnt_q),
      .cnt_d     (cnt_d),
      .cnt_n     (cnt_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: inventory index 0=quarter, 1=dime, 2=nickel.
   int         inv [3];
   int         val [3] = '{25, 10, 5};
   logic [1:0] code[3] = '{2'b11, 2'b10, 2'b01};
   logic [1:0] exp_coins[$];
   int         exp_short;

   // Observations from the last payout.
   logic [1:0] obs_coins[$];
   int         obs_short;
   int         obs_done_cyc;
   int         obs_first_coin;
   int         obs_hold_err;
   bit         obs_timeout;
   bit         obs_done_after;
   bit         obs_ready_busy;

   task automatic model_reload();
      for (int i = 0; i < 3; i++) inv[i] = 20;
   endtask

   task automatic model_pay(input int amt);
      int  rem;
      bit  found;
      rem = amt;
      exp_coins.delete();
      forever begin
         found = 0;
         for (int i = 0; i < 3; i++) begin
            if (!found && val[i] <= rem && inv[i] > 0) begin
               found = 1;
               rem -= val[i];
               inv[i]--;
               exp_coins.push_back(code[i]);
            end
         end
         if (!found) break;
      end
      exp_short = rem;
   endtask

   function automatic bit coins_match();
      if (obs_coins.size() != exp_coins.size()) return 0;
      foreach (obs_coins[i]) if (obs_coins[i] !== exp_coins[i]) return 0;
      return 1;
   endfunction

   // Drives one request and plays the hopper; ack_dly<0 picks a random 0..3 wait per coin.
   task automatic do_payout(input int amt, input int ack_dly, input bit refill_mid, input bit refill_same);
      int         cyc;
      int         wcnt;
      int         dly;
      logic [1:0] h_type;
      logic [5:0] hq, hd, hn;
      obs_coins.delete();
      obs_short      = -1;
      obs_done_cyc   = -1;
      obs_first_coin = -1;
      obs_hold_err   = 0;
      obs_timeout    = 0;
      obs_ready_busy = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_amount = amt[7:0];
      refill     = refill_same;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      refill     = 1'b0;
      req_amount = 8'($urandom);
      cyc  = 0;
      wcnt = 0;
      dly  = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
      forever begin
         @(negedge clk);
         cyc++;
         coin_ack = 1'b0;
         refill   = 1'b0;
         if (req_ready) obs_ready_busy = 1;
         if (done) begin
            obs_short    = int'(shortfall);
            obs_done_cyc = cyc;
            break;
         end
         if (coin_valid) begin
            if (obs_first_coin < 0) obs_first_coin = cyc;
            if (wcnt == 0) begin
               h_type = coin_type; hq = cnt_q; hd = cnt_d; hn = cnt_n;
            end else if (coin_type !== h_type || cnt_q !== hq || cnt_d !== hd || cnt_n !== hn) begin
               obs_hold_err++;
            end
            if (wcnt == dly) begin
               coin_ack = 1'b1;
               obs_coins.push_back(coin_type);
               wcnt = 0;
               dly  = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
            end else begin
               wcnt++;
               if (refill_mid) refill = 1'b1;
            end
         end else if (ack_dly < 0) begin
            coin_ack = 1'($urandom_range(0, 1));
         end
         if (cyc > 400) begin
            obs_timeout = 1;
            break;
         end
      end
      @(negedge clk);
      coin_ack       = 1'b0;
      obs_done_after = done;
   endtask

   task automatic do_refill();
      @(negedge clk);
      refill = 1'b1;
      @(negedge clk);
      refill = 1'b0;
      model_reload();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      model_reload();
      n_vec++;
      if (coin_valid !== 1'b0 || coin_type !== 2'b00) begin
         n_err++; $display("FAIL reset_coin: valid=%b type=%b required 0/00", coin_valid, coin_type);
      end
      n_vec++;
      if (done !== 1'b0 || shortfall !== 8'd0) begin
         n_err++; $display("FAIL reset_done: done=%b short=%0d required 0/0", done, shortfall);
      end
      n_vec++;
      if (cnt_q !== 6'(inv[0]) || cnt_d !== 6'(inv[1]) || cnt_n !== 6'(inv[2])) begin
         n_err++; $display("FAIL reset_cnt: %0d/%0d/%0d required %0d/%0d/%0d", cnt_q, cnt_d, cnt_n, inv[0], inv[1], inv[2]);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_basic();
      model_pay(40);
      do_payout(40, 0, 0, 0);
      n_vec++;
      if (!coins_match() || obs_timeout) begin
         n_err++; $display("FAIL basic_coins: got %0d coins required %0d (timeout=%b)", obs_coins.size(), exp_coins.size(), obs_timeout);
      end
      n_vec++;
      if (obs_short !== exp_short) begin
         n_err++; $display("FAIL basic_short: got %0d required %0d", obs_short, exp_short);
      end
      n_vec++;
      if (cnt_q !== 6'd19 || cnt_d !== 6'd19 || cnt_n !== 6'd19) begin
         n_err++; $display("FAIL basic_cnt: %0d/%0d/%0d required 19/19/19", cnt_q, cnt_d, cnt_n);
      end
      n_vec++;
      if (obs_first_coin !== 2) begin
         n_err++; $display("FAIL basic_first_coin: cycle %0d required 2", obs_first_coin);
      end
      n_vec++;
      if (obs_ready_busy || obs_done_after) begin
         n_err++; $display("FAIL basic_ready_done: ready_busy=%b done_after=%b required 0/0", obs_ready_busy, obs_done_after);
      end
   endtask

   task automatic test_odd_and_zero();
      model_pay(7);
      do_payout(7, -1, 0, 0);
      n_vec++;
      if (!coins_match() || obs_short !== 2 || obs_timeout) begin
         n_err++; $display("FAIL odd_amount: coins=%0d short=%0d required coins=%0d short=2", obs_coins.size(), obs_short, exp_coins.size());
      end
      n_vec++;
      if (cnt_n !== 6'(inv[2])) begin
         n_err++; $display("FAIL odd_cnt_n: got %0d required %0d", cnt_n, inv[2]);
      end
      model_pay(0);
      do_payout(0, 0, 0, 0);
      n_vec++;
      if (obs_coins.size() != 0 || obs_first_coin != -1 || obs_short !== 0) begin
         n_err++; $display("FAIL zero_amount: coins=%0d short=%0d required 0/0", obs_coins.size(), obs_short);
      end
      n_vec++;
      if (obs_done_cyc !== 2) begin
         n_err++; $display("FAIL zero_latency: done cycle %0d required 2", obs_done_cyc);
      end
   endtask

   task automatic test_hold();
      model_pay(10);
      do_payout(10, 5, 1, 0);
      n_vec++;
      if (obs_hold_err !== 0) begin
         n_err++; $display("FAIL hold_stable: %0d unstable cycles required 0", obs_hold_err);
      end
      n_vec++;
      if (!coins_match() || cnt_q !== 6'(inv[0]) || cnt_d !== 6'(inv[1]) || cnt_n !== 6'(inv[2])) begin
         n_err++; $display("FAIL hold_cnt: %0d/%0d/%0d required %0d/%0d/%0d", cnt_q, cnt_d, cnt_n, inv[0], inv[1], inv[2]);
      end
   endtask

   task automatic test_no_quarters();
      int amts[3] = '{250, 250, 30};
      do_refill();
      foreach (amts[i]) begin
         model_pay(amts[i]);
         do_payout(amts[i], -1, 0, 0);
         n_vec++;
         if (!coins_match() || obs_short !== exp_short || obs_timeout) begin
            n_err++; $display("FAIL no_q_%0d: coins=%0d short=%0d required coins=%0d short=%0d", amts[i], obs_coins.size(), obs_short, exp_coins.size(), exp_short);
         end
      end
      n_vec++;
      if (cnt_q !== 6'd0 || cnt_d !== 6'd17) begin
         n_err++; $display("FAIL no_q_cnt: q=%0d d=%0d required 0/17", cnt_q, cnt_d);
      end
   endtask

   task automatic test_shortfall();
      int amts[3] = '{170, 95, 15};
      foreach (amts[i]) begin
         model_pay(amts[i]);
         do_payout(amts[i], -1, 0, 0);
         n_vec++;
         if (!coins_match() || obs_short !== exp_short || obs_timeout) begin
            n_err++; $display("FAIL short_%0d: coins=%0d short=%0d required coins=%0d short=%0d", amts[i], obs_coins.size(), obs_short, exp_coins.size(), exp_short);
         end
      end
      n_vec++;
      if (obs_short !== 10 || cnt_n !== 6'd0) begin
         n_err++; $display("FAIL short_exhaust: short=%0d n=%0d required 10/0", obs_short, cnt_n);
      end
      model_reload();
      model_pay(25);
      do_payout(25, 0, 0, 1);
      n_vec++;
      if (!coins_match() || cnt_q !== 6'd19 || cnt_n !== 6'd20) begin
         n_err++; $display("FAIL refill_same_edge: coins=%0d q=%0d n=%0d required 1/19/20", obs_coins.size(), cnt_q, cnt_n);
      end
   endtask

   task automatic test_random();
      int  amt;
      bit  rf_same;
      for (int t = 0; t < 40; t++) begin
         amt     = int'($urandom_range(0, 255));
         rf_same = ($urandom_range(0, 9) == 0);
         if (rf_same) model_reload();
         model_pay(amt);
         do_payout(amt, -1, 1'($urandom_range(0, 1)), rf_same);
         n_vec++;
         if (!coins_match() || obs_short !== exp_short || obs_timeout || obs_hold_err != 0) begin
            n_err++; $display("FAIL rand_pay amt=%0d: coins=%0d short=%0d required coins=%0d short=%0d", amt, obs_coins.size(), obs_short, exp_coins.size(), exp_short);
         end
         n_vec++;
         if (cnt_q !== 6'(inv[0]) || cnt_d !== 6'(inv[1]) || cnt_n !== 6'(inv[2])) begin
            n_err++; $display("FAIL rand_cnt amt=%0d: %0d/%0d/%0d required %0d/%0d/%0d", amt, cnt_q, cnt_d, cnt_n, inv[0], inv[1], inv[2]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int  n;
      bit  seen_done;
      do_refill();
      @(negedge clk);
      req_valid  = 1'b1;
      req_amount = 8'd40;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      seen_done = 0;
      // Ack the quarter, then leave the dime pending.
      while (!coin_valid && n < 10) begin @(negedge clk); n++; end
      coin_ack = 1'b1;
      @(negedge clk);
      coin_ack = 1'b0;
      while (!coin_valid && n < 20) begin @(negedge clk); n++; end
      n_vec++;
      if (coin_valid !== 1'b1 || cnt_q !== 6'd19) begin
         n_err++; $display("FAIL mid_setup: valid=%b q=%0d required 1/19", coin_valid, cnt_q);
      end
      #2 rst = 1'b0;
      #1;
      model_reload();
      n_vec++;
      if (coin_valid !== 1'b0 || coin_type !== 2'b00 || done !== 1'b0) begin
         n_err++; $display("FAIL mid_reset_out: valid=%b type=%b done=%b required 0/00/0", coin_valid, coin_type, done);
      end
      n_vec++;
      if (cnt_q !== 6'(inv[0]) || cnt_d !== 6'(inv[1]) || cnt_n !== 6'(inv[2])) begin
         n_err++; $display("FAIL mid_reset_cnt: %0d/%0d/%0d required 20/20/20", cnt_q, cnt_d, cnt_n);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) seen_done = 1;
      end
      n_vec++;
      if (seen_done || req_ready !== 1'b1) begin
         n_err++; $display("FAIL mid_after: done_seen=%b ready=%b required 0/1", seen_done, req_ready);
      end
   endtask

   initial begin
      req_valid  = 1'b0;
      req_amount = 8'd0;
      coin_ack   = 1'b0;
      refill     = 1'b0;
      test_reset();
      test_basic();
      test_odd_and_zero();
      test_hold();
      test_no_quarters();
      test_shortfall();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
